apb_requester_arbiter: RTL

APB requester (bus-side controller) that shares one APB bus among NUM_REQ local command sources. It round-robin arbitrates valid/ready command requests and sequences each granted command through the APB IDLE, SETUP and ACCESS phases. It returns read data and error status to the granted source, and aborts stalled transfers with a wait-state timeout. It drives the bus-side signals of the team's APB interface.

---
 rtl/apb_requester_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/apb_requester_arbiter.sv
// Shares one APB bus among NUM_REQ command sources with round-robin arbitration,
// full IDLE/SETUP/ACCESS sequencing and an optional wait-state timeout.
package apb_pkg;
    parameter int ADDR_WIDTH = 32;
    parameter int DATA_WIDTH = 32;
endpackage

module apb_requester_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_WIDTH     = apb_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH     = apb_pkg::DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                             pclk,
    input  logic                             presetn,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ-1:0]               req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
    output logic [NUM_REQ-1:0]               rsp_valid,
    output logic [DATA_WIDTH-1:0]            rsp_rdata,
    output logic                             rsp_slverr,
    output logic                             rsp_timeout,
    output logic [ADDR_WIDTH-1:0]            paddr,
    output logic                             psel,
    output logic                             penable,
    output logic                             pwrite,
    output logic [DATA_WIDTH-1:0]            pwdata,
    input  logic [DATA_WIDTH-1:0]            prdata,
    input  logic                             pready,
    input  logic                             pslverr
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_t;

    state_t           state, state_next;
    logic [IDX_W-1:0] last_grant;
    logic [IDX_W-1:0] grant;
    logic             grant_found;
    logic [CNT_W-1:0] wait_cnt;
    logic             timeout_hit;
    int               cand;

    // Cyclic search starting just after the previous winner; last_grant itself is checked last.
    always_comb begin
        grant       = last_grant;
        grant_found = 1'b0;
        cand        = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(last_grant) + k) % NUM_REQ;
            if (!grant_found && req_valid[cand]) begin
                grant       = IDX_W'(cand);
                grant_found = 1'b1;
            end
        end
    end

    assign timeout_hit = (TIMEOUT_CYCLES > 0) && ((int'(wait_cnt) + 1) == TIMEOUT_CYCLES);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant_found) state_next = SETUP;
            SETUP:   state_next = ACCESS;
            ACCESS:  if (pready || timeout_hit) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Gated by presetn so a held req_valid cannot leak a ready while reset is asserted.
    always_comb begin
        req_ready = '0;
        if (presetn && (state == IDLE) && grant_found) begin
            req_ready[grant] = 1'b1;
        end
    end

    assign psel    = (state != IDLE);
    assign penable = (state == ACCESS);

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            last_grant  <= IDX_W'(NUM_REQ - 1);
            paddr       <= '0;
            pwrite      <= 1'b0;
            pwdata      <= '0;
            wait_cnt    <= '0;
            rsp_valid   <= '0;
            rsp_rdata   <= '0;
            rsp_slverr  <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            rsp_valid <= '0;
            case (state)
                IDLE: begin
                    wait_cnt <= '0;
                    if (grant_found) begin
                        paddr      <= req_addr[grant*ADDR_WIDTH +: ADDR_WIDTH];
                        pwrite     <= req_write[grant];
                        pwdata     <= req_write[grant] ? req_wdata[grant*DATA_WIDTH +: DATA_WIDTH]
                                                       : '0;
                        last_grant <= grant;
                    end
                end
                ACCESS: begin
                    if (pready) begin
                        rsp_valid   <= {{(NUM_REQ-1){1'b0}}, 1'b1} << last_grant;
                        rsp_rdata   <= pwrite ? '0 : prdata;
                        rsp_slverr  <= pslverr;
                        rsp_timeout <= 1'b0;
                        wait_cnt    <= '0;
                    end else if (timeout_hit) begin
                        rsp_valid   <= {{(NUM_REQ-1){1'b0}}, 1'b1} << last_grant;
                        rsp_rdata   <= '0;
                        rsp_slverr  <= 1'b1;
                        rsp_timeout <= 1'b1;
                        wait_cnt    <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
